// File: rtl/kc_pkg.sv
// Shared types and constants for the keycode event path.
package kc_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  typedef enum logic [1:0] {
    S_TRACK = 2'b00,
    S_REL   = 2'b01,
    S_PRS   = 2'b10
  } kc_state_t;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;

  function automatic logic is_left(input logic [7:0] code);
    return (code == KC_A) || (code == KC_LEFT);
  endfunction

  function automatic logic is_right(input logic [7:0] code);
    return (code == KC_D) || (code == KC_RIGHT);
  endfunction

endpackage

// File: rtl/kc_event_fifo.sv
// First-word-through event FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and counted.
module kc_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow,
  output logic [7:0]       o_drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic [7:0]       r_drop_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = i_push && (!w_full || w_pop);
  assign w_drop  = i_push && w_full && !w_pop;

  // Storage write; no reset so the array maps onto plain memory.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  // Pointer, overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign o_valid      = !w_empty;
  assign o_data       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the HID keycode, emits press/release/repeat events through a
// FIFO and produces frame-latched left/right movement levels.
module keycode_event_decoder
  import kc_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_RATE   = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  output logic       evt_valid,
  output logic [9:0] evt_data,
  input  logic       evt_ready,
  output logic       move_left,
  output logic       move_right,
  output logic [7:0] accepted_code,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int             SW        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]  STAB_MAX  = SW'(STABLE_CYCLES - 1);
  localparam logic [7:0]     RPT_FIRST = 8'(REPEAT_DELAY);
  localparam logic [7:0]     RPT_NEXT  = 8'(REPEAT_DELAY + REPEAT_RATE);

  logic [7:0]    r_cand;
  logic [SW-1:0] r_stab_cnt;
  kc_state_t     r_state;
  logic [7:0]    r_acc;
  logic [7:0]    r_old;
  logic [7:0]    r_new;
  logic          r_fc;
  logic          r_fc_d;
  logic          r_move_left;
  logic          r_move_right;
  logic [7:0]    r_rpt_cnt;
  logic          r_rpt_pend;

  logic          w_commit;
  logic          w_tick;
  logic [7:0]    w_rpt_inc;
  logic          w_fire;
  logic          w_fsm_push;
  logic          w_rpt_push;
  logic          w_push;
  logic [9:0]    w_push_data;

  // Candidate register and stability counter (reset on any change of the candidate).
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cand     <= KC_NONE;
      r_stab_cnt <= '0;
    end else begin
      r_cand <= keycode;
      if (keycode != r_cand) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  assign w_commit = (r_stab_cnt == STAB_MAX) && (r_cand != r_acc) && (r_state == S_TRACK);

  // Event sequencer: release of the old key, then press of the new key.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_TRACK;
      r_acc   <= KC_NONE;
      r_old   <= KC_NONE;
      r_new   <= KC_NONE;
    end else begin
      case (r_state)
        S_TRACK: begin
          if (w_commit) begin
            r_old   <= r_acc;
            r_new   <= r_cand;
            r_acc   <= r_cand;
            r_state <= (r_acc != KC_NONE) ? S_REL : S_PRS;
          end
        end
        S_REL:   r_state <= (r_new != KC_NONE) ? S_PRS : S_TRACK;
        S_PRS:   r_state <= S_TRACK;
        default: r_state <= S_TRACK;
      endcase
    end
  end

  assign w_tick    = r_fc && !r_fc_d;
  assign w_rpt_inc = (r_rpt_cnt == 8'hFF) ? 8'hFF : r_rpt_cnt + 8'd1;
  assign w_fire    = w_tick && (r_acc == KC_SPACE) &&
                     ((w_rpt_inc == RPT_FIRST) || (w_rpt_inc == RPT_NEXT));

  // Frame edge detect, movement latches and shoot-key auto-repeat timing.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_fc         <= 1'b0;
      r_fc_d       <= 1'b0;
      r_move_left  <= 1'b0;
      r_move_right <= 1'b0;
      r_rpt_cnt    <= 8'd0;
      r_rpt_pend   <= 1'b0;
    end else begin
      r_fc   <= frame_clk;
      r_fc_d <= r_fc;
      if (w_tick) begin
        r_move_left  <= is_left(r_acc);
        r_move_right <= is_right(r_acc);
      end
      if (r_acc != KC_SPACE) begin
        r_rpt_cnt <= 8'd0;
      end else if (w_tick) begin
        // After the first repeat the counter cycles between DELAY and DELAY+RATE.
        r_rpt_cnt <= (w_rpt_inc == RPT_NEXT) ? RPT_FIRST : w_rpt_inc;
      end
      r_rpt_pend <= (r_rpt_pend && !w_rpt_push) || w_fire;
    end
  end

  // FIFO write source: sequencer pushes take priority over a pending repeat.
  always_comb begin
    w_fsm_push  = (r_state == S_REL) || (r_state == S_PRS);
    w_rpt_push  = r_rpt_pend && !w_fsm_push;
    w_push      = w_fsm_push || w_rpt_push;
    w_push_data = {EVT_REPEAT, KC_SPACE};
    if (r_state == S_REL) begin
      w_push_data = {EVT_RELEASE, r_old};
    end else if (r_state == S_PRS) begin
      w_push_data = {EVT_PRESS, r_new};
    end
  end

  kc_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (evt_ready),
    .o_valid      (evt_valid),
    .o_data       (evt_data),
    .o_overflow   (overflow),
    .o_drop_count (drop_count)
  );

  assign move_left     = r_move_left;
  assign move_right    = r_move_right;
  assign accepted_code = r_acc;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Self-checking bench for keycode_event_decoder: event-level reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_keycode_event_decoder;

  localparam int SC    = 1000;
  localparam int DEPTH = 8;
  localparam int RDLY  = 15;
  localparam int RRATE = 4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       frame_clk;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic       evt_ready;
  logic       move_left;
  logic       move_right;
  logic [7:0] accepted_code;
  logic       overflow;
  logic [7:0] drop_count;

  keycode_event_decoder #(
    .STABLE_CYCLES (SC),
    .FIFO_DEPTH    (DEPTH),
    .REPEAT_DELAY  (RDLY),
    .REPEAT_RATE   (RRATE)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .keycode       (keycode),
    .frame_clk     (frame_clk),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready),
    .move_left     (move_left),
    .move_right    (move_right),
    .accepted_code (accepted_code),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // ---------------- reference model state ----------------
  logic [7:0] m_run_val;
  int         m_run_len;
  logic [7:0] m_acc;
  logic [9:0] m_pend [$];
  logic [9:0] m_fifo [$];
  bit         m_ovf;
  int         m_drop;
  bit         m_ml, m_mr;
  bit         m_fc1, m_fc2;
  int         m_space_ticks;
  bit         m_rpt_pend;
  logic [9:0] dut_log [$];

  // frame generator controls
  bit fr_en = 0;
  int fr_half = 10;

  task automatic model_reset();
    m_run_val = 8'h00; m_run_len = 1; m_acc = 8'h00;
    m_pend.delete(); m_fifo.delete();
    m_ovf = 0; m_drop = 0; m_ml = 0; m_mr = 0;
    m_fc1 = 0; m_fc2 = 0; m_space_ticks = 0; m_rpt_pend = 0;
  endtask

  // Model: advances one clock using the inputs that were stable before the edge.
  initial begin
    bit         tick, pop, have, track;
    logic [9:0] pdata;
    logic [7:0] acc_before;
    model_reset();
    forever begin
      @(posedge Clk);
      if (Reset_n && evt_valid && evt_ready) dut_log.push_back(evt_data);
      if (!Reset_n) begin
        model_reset();
      end else begin
        tick       = m_fc1 && !m_fc2;
        track      = (m_pend.size() == 0);
        acc_before = m_acc;
        pop        = evt_ready && (m_fifo.size() > 0);
        have       = 0;
        pdata      = '0;
        if (m_pend.size() > 0) begin
          pdata = m_pend.pop_front(); have = 1;
        end else if (m_rpt_pend) begin
          pdata = {2'b11, 8'h2C}; have = 1; m_rpt_pend = 0;
        end
        // a key is accepted once the same value has been seen SC times in a row
        if (track && m_run_len >= SC && m_run_val != m_acc) begin
          if (m_acc != 8'h00)     m_pend.push_back({2'b10, m_acc});
          if (m_run_val != 8'h00) m_pend.push_back({2'b01, m_run_val});
          m_acc = m_run_val;
        end
        if (acc_before != 8'h2C) begin
          m_space_ticks = 0;
        end else if (tick) begin
          m_space_ticks++;
          if (m_space_ticks == RDLY ||
              (m_space_ticks > RDLY && (m_space_ticks - RDLY) % RRATE == 0))
            m_rpt_pend = 1;
        end
        if (tick) begin
          m_ml = (acc_before == 8'h04) || (acc_before == 8'h50);
          m_mr = (acc_before == 8'h07) || (acc_before == 8'h4F);
        end
        if (pop) void'(m_fifo.pop_front());
        if (have) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(pdata);
          else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
        if (keycode == m_run_val) m_run_len++;
        else begin m_run_val = keycode; m_run_len = 1; end
        m_fc2 = m_fc1;
        m_fc1 = frame_clk;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [9:0] exp);
    logic [31:0] act;
    act = (idx < dut_log.size()) ? 32'(dut_log[idx]) : 32'hDEAD;
    chk(nm, act, 32'(exp));
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge Clk);
      if (cmp_en) begin
        chk("evt_valid",     32'(evt_valid),     32'(m_fifo.size() > 0));
        chk("evt_data",      32'(evt_data),      (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'h0);
        chk("accepted_code", 32'(accepted_code), 32'(m_acc));
        chk("move_left",     32'(move_left),     32'(m_ml));
        chk("move_right",    32'(move_right),    32'(m_mr));
        chk("overflow",      32'(overflow),      32'(m_ovf));
        chk("drop_count",    32'(drop_count),    32'(m_drop));
      end
    end
  end

  // Frame clock: square wave of 2*fr_half cycles while enabled, low otherwise.
  initial begin
    int cnt;
    frame_clk = 1'b0;
    cnt = 0;
    forever begin
      @(negedge Clk);
      if (fr_en) begin
        cnt++;
        if (cnt >= fr_half) begin frame_clk = ~frame_clk; cnt = 0; end
      end else begin
        frame_clk = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog timeout");
  end

  task automatic apply_reset();
    @(negedge Clk); Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic wait_acc(input string nm, input logic [7:0] v, input int lim, output int n);
    n = 0;
    while (accepted_code !== v && n < lim) begin @(negedge Clk); n++; end
    chk(nm, 32'(accepted_code), 32'(v));
  endtask

  task automatic wait_sig(input string nm, input bit want_left, input int lim);
    int n;
    n = 0;
    while ((want_left ? move_left : move_right) !== 1'b1 && n < lim) begin @(negedge Clk); n++; end
    chk(nm, 32'(want_left ? move_left : move_right), 32'h1);
  endtask

  logic [7:0] kc_tab [8] = '{8'h00, 8'h04, 8'h07, 8'h2C, 8'h50, 8'h4F, 8'h2C, 8'h1D};
  logic [7:0] seq5   [6] = '{8'h04, 8'h07, 8'h04, 8'h07, 8'h04, 8'h00};
  logic [9:0] exp5   [8] = '{10'h104, 10'h204, 10'h107, 10'h207, 10'h104, 10'h204, 10'h107, 10'h207};
  logic [9:0] exp4   [6] = '{10'h12C, 10'h32C, 10'h32C, 10'h32C, 10'h32C, 10'h22C};

  initial begin
    int n, i0;
    Reset_n = 1'b0; keycode = 8'h00; evt_ready = 1'b0;
    repeat (3) @(negedge Clk);
    cmp_en = 1;
    Reset_n = 1'b1;
    // reset state
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_data",  32'(evt_data), 0);
    chk("rst_acc",   32'(accepted_code), 0);
    chk("rst_ml",    32'(move_left), 0);
    chk("rst_mr",    32'(move_right), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_drop",  32'(drop_count), 0);
    fr_en = 1; fr_half = 10; evt_ready = 1'b1;

    // 1: A pressed; accepted after exactly SC+1 edges, one press event, move_left
    i0 = dut_log.size();
    keycode = 8'h04;
    wait_acc("t1_accept", 8'h04, 1500, n);
    chk("t1_latency", 32'(n), 32'(SC + 1));
    repeat (5) @(negedge Clk);
    chk_log("t1_press", i0, 10'h104);
    wait_sig("t1_move_left", 1'b1, 100);

    // 2: A -> D gives release then press
    i0 = dut_log.size();
    keycode = 8'h07;
    wait_acc("t2_accept", 8'h07, 1500, n);
    repeat (5) @(negedge Clk);
    chk_log("t2_release", i0, 10'h204);
    chk_log("t2_press", i0 + 1, 10'h107);
    wait_sig("t2_move_right", 1'b0, 100);
    chk("t2_move_left_clear", 32'(move_left), 0);

    // 3: space/none toggling faster than the debounce window produces nothing
    keycode = 8'h00;
    wait_acc("t3_idle", 8'h00, 1500, n);
    repeat (5) @(negedge Clk);
    i0 = dut_log.size();
    for (int s = 0; s < 20; s++) begin
      keycode = (s % 2 == 0) ? 8'h2C : 8'h00;
      repeat (500) @(negedge Clk);
    end
    chk("t3_no_events", 32'(dut_log.size()), 32'(i0));
    chk("t3_acc", 32'(accepted_code), 0);

    // 4: space held for 30 frames: press, repeats at frames 15/19/23/27, release
    i0 = dut_log.size();
    keycode = 8'h2C;
    wait_acc("t4_accept", 8'h2C, 1500, n);
    n = 0;
    while (m_space_ticks < 30 && n < 2000) begin @(negedge Clk); n++; end
    chk("t4_frames", 32'(m_space_ticks), 30);
    fr_en = 0;
    keycode = 8'h00;
    wait_acc("t4_release", 8'h00, 1500, n);
    repeat (5) @(negedge Clk);
    chk("t4_count", 32'(dut_log.size() - i0), 6);
    for (int k = 0; k < 6; k++) chk_log($sformatf("t4_evt%0d", k), i0 + k, exp4[k]);
    fr_en = 1;

    // 5: 10 events into a stalled FIFO: 8 kept in order, 2 dropped
    keycode = 8'h00; evt_ready = 1'b0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      keycode = seq5[k];
      wait_acc($sformatf("t5_key%0d", k), seq5[k], 1500, n);
      repeat (3) @(negedge Clk);
    end
    chk("t5_overflow", 32'(overflow), 1);
    chk("t5_drops", 32'(drop_count), 2);
    i0 = dut_log.size();
    evt_ready = 1'b1;
    repeat (12) @(negedge Clk);
    for (int k = 0; k < 8; k++) chk_log($sformatf("t5_pop%0d", k), i0 + k, exp5[k]);
    chk("t5_drained", 32'(evt_valid), 0);

    // 5b: push while full with a simultaneous pop is not a drop
    evt_ready = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      keycode = seq5[k];
      wait_acc($sformatf("t5b_key%0d", k), seq5[k], 1500, n);
      repeat (3) @(negedge Clk);
    end
    keycode = 8'h04;
    n = 0;
    while (!(m_fifo.size() == DEPTH && m_pend.size() > 0) && n < 1500) begin @(negedge Clk); n++; end
    chk("t5b_full_seen", 32'(m_fifo.size()), DEPTH);
    evt_ready = 1'b1;
    @(negedge Clk);
    evt_ready = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t5b_no_overflow", 32'(overflow), 0);
    chk("t5b_no_drop", 32'(drop_count), 0);
    evt_ready = 1'b1;
    repeat (12) @(negedge Clk);

    // 6: reset while releasing with 3 events queued
    keycode = 8'h00; evt_ready = 1'b0;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      keycode = seq5[k];
      wait_acc($sformatf("t6_key%0d", k), seq5[k], 1500, n);
      repeat (3) @(negedge Clk);
    end
    chk("t6_queued", 32'(m_fifo.size()), 3);
    keycode = 8'h04;
    n = 0;
    while (m_pend.size() != 2 && n < 1500) begin @(negedge Clk); n++; end
    chk("t6_in_release", 32'(m_pend.size()), 2);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("t6_valid", 32'(evt_valid), 0);
    chk("t6_acc", 32'(accepted_code), 0);

    // randomized phase
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 11) == 0) apply_reset();
      keycode = kc_tab[$urandom_range(0, 7)];
      fr_half = $urandom_range(3, 12);
      repeat ($urandom_range(1, 1600)) begin
        @(negedge Clk);
        evt_ready = ($urandom_range(0, 3) != 0);
      end
    end
    evt_ready = 1'b1;
    keycode = 8'h00;
    wait_acc("rnd_final_idle", 8'h00, 1500, n);
    fr_en = 0;
    repeat (20) @(negedge Clk);
    chk("rnd_final_drained", 32'(evt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keycode_event_decoder.md
Name: keycode_event_decoder

Overview:
- Consumer end of the keycode path. The SoC keycode PIO writes an 8-bit USB HID keycode.
- This block debounces that keycode and turns changes into press/release/repeat events.
- Events pass through a small FIFO with a valid/ready handshake to game logic.
- It also drives frame-synchronous movement levels (left/right) for jumplogic, updated on the VGA vertical-sync edge.

Parameters:
- STABLE_CYCLES, 1000: clocks a keycode must hold unchanged before it is accepted (20 us at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; power of two, at least 2.
- REPEAT_DELAY, 15: frames the shoot key must be held before the first repeat event.
- REPEAT_RATE, 4: frames between later repeat events.

Ports:
- Clk in 1: system clock, MAX10_CLK1_50 domain.
- Reset_n in 1: synchronous, active-low reset.
- keycode in 8: raw HID keycode from the SoC PIO; 0x00 means no key.
- frame_clk in 1: VGA_VS, same clock domain; its rising edge marks a frame.
- evt_valid out 1: FIFO head is valid.
- evt_data out 10: {type[1:0], code[7:0]}; type 01 press, 10 release, 11 repeat.
- evt_ready in 1: consumer accepts the head on a cycle where evt_valid && evt_ready.
- move_left out 1: frame-latched; accepted code is 0x04 (A) or 0x50 (left arrow).
- move_right out 1: frame-latched; accepted code is 0x07 (D) or 0x4F (right arrow).
- accepted_code out 8: current debounced keycode.
- overflow out 1: sticky; an event was dropped because the FIFO was full.
- drop_count out 8: dropped events, saturates at 0xFF.

Behaviour:
- Reset (Reset_n=0 at a Clk edge) clears all state:
  - FIFO empty, evt_valid=0, evt_data=0.
  - move_left=0, move_right=0, accepted_code=0x00.
  - overflow=0, drop_count=0, FSM in S_TRACK.
  - Reset mid-operation discards pending FIFO contents and any in-progress debounce.
- Debounce:
  - keycode is registered once, giving the candidate.
  - If the candidate differs from the previous candidate, stab_cnt resets to 0; otherwise it increments, saturating at STABLE_CYCLES-1.
  - Commit condition: stab_cnt==STABLE_CYCLES-1, candidate != accepted_code, and FSM in S_TRACK.
  - Latency: a change stable from cycle 0 commits at cycle STABLE_CYCLES+1.
- FSM (S_TRACK, S_REL, S_PRS):
  - S_TRACK on commit: latch old = accepted_code and new = candidate, then update accepted_code. Go to S_REL if old != 0, else S_PRS.
  - S_REL: push {10, old}. Go to S_PRS if new != 0, else S_TRACK.
  - S_PRS: push {01, new}, then go to S_TRACK.
  - Debounce tracking continues in S_REL and S_PRS. A commit is only evaluated in S_TRACK, so a change during S_REL/S_PRS is taken on the first eligible cycle after returning.
- Frame logic:
  - frame_clk is registered and rising-edge detected, giving frame_tick (one cycle).
  - On frame_tick, move_left and move_right load from accepted_code decode; they hold between ticks.
  - Auto-repeat: rpt_cnt clears whenever accepted_code != 0x2C (space).
  - While accepted_code == 0x2C, rpt_cnt counts frame_ticks. A repeat request {11, 0x2C} fires when rpt_cnt reaches REPEAT_DELAY, then every REPEAT_RATE ticks after that.
  - If a repeat request coincides with an FSM push, the FSM push wins and the repeat is held pending for the next cycle where the FSM does not push.
- FIFO (first-word-through):
  - evt_data shows the head; a push becomes visible on evt_valid the cycle after the write.
  - A simultaneous push and pop while full is allowed: the pop frees a slot, so nothing is dropped.
  - A push while full with no pop drops the event: overflow is set, drop_count increments with saturation, and FIFO contents are unchanged.
  - A pop while empty is ignored.
  - evt_data is held stable while evt_valid && !evt_ready.
- Widths:
  - stab_cnt: $clog2(STABLE_CYCLES) bits.
  - rpt_cnt: 8 bits, saturating.
  - FIFO pointers: $clog2(FIFO_DEPTH)+1 bits, wrapping.

Decomposition:
- Package kc_pkg holds:
  - The evt_type_t enum (EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_REPEAT=2'b11).
  - Keycode constants KC_A=8'h04, KC_D=8'h07, KC_SPACE=8'h2C, KC_LEFT=8'h50, KC_RIGHT=8'h4F.
  - The FSM state enum.
- One sub-module, kc_event_fifo: a parameterised synchronous FIFO with push/pop/full/empty and the drop counter.

Test Plan:
- Reset, then keycode=0x04 held for 1000 cycles -> accepted_code=0x04 at cycle 1001; one event 0x104; move_left=1 after the next frame_clk rise.
- Keycode changes 0x04 to 0x07 and is stable -> events 0x204 then 0x107 on consecutive FIFO writes; move_left=0 and move_right=1 after the next frame.
- Keycode toggles between 0x2C and 0x00 every 500 cycles for 10k cycles -> no events, accepted_code stays 0x00.
- 0x2C held for 30 frames with evt_ready=1 -> one 0x12C, then 0x32C at frame 15 and at frames 19, 23, 27; release 0x22C when the key goes to 0x00.
- evt_ready=0 with 10 events generated -> 8 queued, overflow=1, drop_count=2; with evt_ready=1, pops come out in order; a push and pop in the same cycle while full causes no drop.
- Reset_n=0 asserted mid-S_REL with 3 events queued -> next cycle evt_valid=0, accepted_code=0x00, FSM in S_TRACK.
